parking_slot_timer: RTL

Per-slot parking occupancy timer and fee calculator, downstream of the timer clock divider. It samples the divider's slow square-wave output as data in the `CLK_IN` domain and converts its rising edges into billing-unit ticks. It keeps an elapsed-unit counter for each occupied slot. On vehicle exit it computes the fee with a sequential shift-add multiplier and reports slot, duration and fee with a one-cycle done pulse.

---
 rtl/parking_slot_timer.sv | 119 +++++++++++
 1 files changed

// File: rtl/parking_slot_timer.sv
// parking_slot_timer: per-slot occupancy timer with shift-add fee calculator; PARKING_GRACE_EN enables a free grace period
module parking_slot_timer #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W = 2,
  parameter int TICKS_PER_UNIT = 500,
  parameter int TIME_W = 16,
  parameter int RATE = 5,
  parameter int FEE_W = 24,
  parameter int GRACE_UNITS = 3
) (
  input  logic                 CLK_IN,
  input  logic                 RST,
  input  logic                 TIMER_CLK,
  input  logic [SLOT_W-1:0]    SLOT,
  input  logic                 ENTER,
  input  logic                 EXIT,
  output logic [NUM_SLOTS-1:0] OCCUPIED,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [SLOT_W-1:0]    DONE_SLOT,
  output logic [TIME_W-1:0]    DURATION,
  output logic [FEE_W-1:0]     FEE,
  output logic                 ERROR
);
  typedef enum logic [1:0] {IDLE, MULT, REPORT} state_t;
  localparam int PW = $clog2(TICKS_PER_UNIT + 1);
  localparam int BW = $clog2(TIME_W + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_UNIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(TIME_W - 1);
  localparam logic [SLOT_W:0] NS = (SLOT_W + 1)'(NUM_SLOTS);
  localparam logic [TIME_W-1:0] GRACE = TIME_W'(GRACE_UNITS);
`ifdef PARKING_GRACE_EN
  localparam bit GRACE_EN = 1'b1;
`else
  localparam bit GRACE_EN = 1'b0;
`endif
  state_t state, state_n;
  logic sync1, sync2, tclk_d;
  logic [PW-1:0] pre;
  logic [NUM_SLOTS-1:0][TIME_W-1:0] cnt;
  logic [TIME_W-1:0] cur, mq, dur_r;
  logic [FEE_W-1:0] mc, acc;
  logic [BW-1:0] bit_cnt;
  logic [SLOT_W-1:0] slot_r;
  logic rise, unit, in_range, sel_occ, enter_ok, exit_ok, grace_hit;

  assign rise = sync2 & ~tclk_d;
  assign unit = rise && pre == PRE_LAST;
  assign in_range = {1'b0, SLOT} < NS;
  assign sel_occ = in_range && OCCUPIED[SLOT];
  assign cur = cnt[SLOT];
  assign enter_ok = state == IDLE && ENTER && !EXIT && in_range && !sel_occ;
  assign exit_ok = state == IDLE && EXIT && !ENTER && sel_occ;
  assign grace_hit = GRACE_EN && cur <= GRACE;
  assign BUSY = state != IDLE;

  // Synchronize the divider output, detect its rising edges and divide them down to unit pulses
  always_ff @(posedge CLK_IN or posedge RST)
    if (RST) {sync1, sync2, tclk_d, pre} <= '0;
    else begin
      {sync1, sync2, tclk_d} <= {TIMER_CLK, sync1, sync2};
      if (rise) pre <= unit ? '0 : pre + 1'b1;
    end

  // Per-slot saturating duration counters; an accepted entry clears the counter and swallows a coincident tick
  always_ff @(posedge CLK_IN or posedge RST)
    if (RST) cnt <= '0;
    else
      for (int i = 0; i < NUM_SLOTS; i++)
        if (enter_ok && SLOT == SLOT_W'(i)) cnt[i] <= '0;
        else if (unit && OCCUPIED[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;

  // Occupancy flags
  always_ff @(posedge CLK_IN or posedge RST)
    if (RST) OCCUPIED <= '0;
    else if (enter_ok) OCCUPIED[SLOT] <= 1'b1;
    else if (exit_ok) OCCUPIED[SLOT] <= 1'b0;

  // FSM state register
  always_ff @(posedge CLK_IN or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_n;

  // FSM next state: exit starts the multiply (or jumps straight to report inside the grace period)
  always_comb begin
    state_n = state;
    if (state == IDLE && exit_ok) state_n = grace_hit ? REPORT : MULT;
    if (state == MULT && bit_cnt == BIT_LAST) state_n = REPORT;
    if (state == REPORT) state_n = IDLE;
  end

  // Capture on exit, LSB-first shift-add multiply, publish results and pulses
  always_ff @(posedge CLK_IN or posedge RST)
    if (RST) begin
      {mq, mc, acc, bit_cnt, slot_r, dur_r} <= '0;
      {DONE, ERROR, DONE_SLOT, DURATION, FEE} <= '0;
    end else begin
      ERROR <= (ENTER || EXIT) && !enter_ok && !exit_ok;
      DONE <= state == REPORT;
      if (exit_ok) begin
        slot_r <= SLOT;
        dur_r <= cur;
        mq <= cur == '0 ? TIME_W'(1) : cur;
        mc <= FEE_W'(RATE);
        acc <= '0;
        bit_cnt <= '0;
      end else if (state == MULT) begin
        if (mq[0]) acc <= acc + mc;
        mq <= mq >> 1;
        mc <= mc << 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == REPORT) begin
        DONE_SLOT <= slot_r;
        DURATION <= dur_r;
        FEE <= acc;
      end
    end
endmodule
